// File: rtl/hs_pkg.sv
// Shared definitions for the high-score uploader.
package hs_pkg;

    localparam logic [7:0]  HS_INDEX_DEFAULT = 8'd4;
    localparam int unsigned HS_LAT_W         = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_ARM     = 3'd2,
        ST_WAIT_UP = 3'd3,
        ST_SERVE   = 3'd4,
        ST_FETCH   = 3'd5,
        ST_DONE    = 3'd6
    } hs_state_e;

endpackage

// File: rtl/hs_timeout.sv
// Upload-start watchdog: counts enabled cycles, flags once the counter reaches all-ones.
module hs_timeout #(
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {TIMEOUT_W{1'b1}};

    logic [TIMEOUT_W-1:0] cnt;

    // Count while enabled; hold once expired so the flag cannot wrap away.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || clear) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (enable && !expire) begin
            cnt    <= cnt + TIMEOUT_W'(1);
            expire <= (cnt == CNT_LAST - TIMEOUT_W'(1));
        end
    end

endmodule

// File: rtl/hs_uploader.sv
// Halts the core, asks the HPS for an upload and serves game-RAM bytes over ioctl.
module hs_uploader
    import hs_pkg::*;
#(
    parameter logic [7:0]  INDEX     = HS_INDEX_DEFAULT,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned LENGTH    = 2048,
    parameter int unsigned RAM_LAT   = 1,
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              save_req,
    input  logic              paused,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_index,
    input  logic [7:0]        ram_data,
    output logic [7:0]        ioctl_din,
    output logic              upload_req,
    output logic              pause_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              busy,
    output logic              abort
);

    localparam int unsigned          IOCTL_AW  = 25;
    localparam logic [IOCTL_AW-1:0]  LEN_LIMIT = IOCTL_AW'(LENGTH);
    localparam logic [HS_LAT_W-1:0]  LAT_LAST  = HS_LAT_W'(RAM_LAT);

    hs_state_e             state, nxt_state;
    logic                  save_q;
    logic                  pending, nxt_pending;
    logic [HS_LAT_W-1:0]   lat_cnt, nxt_lat;
    logic                  oor_q, nxt_oor;
    logic [7:0]            nxt_din;
    logic                  nxt_upload_req, nxt_pause_req;
    logic [ADDR_W-1:0]     nxt_ram_addr;
    logic                  nxt_ram_rd, nxt_busy, nxt_abort;

    logic                  save_rise;
    logic                  rd_hit;
    logic                  in_range;
    logic                  tmo_clear, tmo_enable, tmo_expire;

    assign save_rise  = save_req & ~save_q;
    assign rd_hit     = ioctl_rd && (ioctl_index == INDEX);
    assign in_range   = ioctl_addr < LEN_LIMIT;
    assign tmo_enable = (state == ST_WAIT_UP);
    assign tmo_clear  = (state != ST_WAIT_UP);

    // Watchdog on the wait for the HPS to open the upload window.
    hs_timeout #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timeout (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expire  (tmo_expire)
    );

    // State and registered outputs; reset forces everything idle and quiet.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            save_q     <= 1'b0;
            pending    <= 1'b0;
            lat_cnt    <= '0;
            oor_q      <= 1'b0;
            ioctl_din  <= 8'h00;
            upload_req <= 1'b0;
            pause_req  <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            busy       <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= nxt_state;
            save_q     <= save_req;
            pending    <= nxt_pending;
            lat_cnt    <= nxt_lat;
            oor_q      <= nxt_oor;
            ioctl_din  <= nxt_din;
            upload_req <= nxt_upload_req;
            pause_req  <= nxt_pause_req;
            ram_addr   <= nxt_ram_addr;
            ram_rd     <= nxt_ram_rd;
            busy       <= nxt_busy;
            abort      <= nxt_abort;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        nxt_state      = state;
        nxt_pending    = pending;
        nxt_lat        = lat_cnt;
        nxt_oor        = oor_q;
        nxt_din        = ioctl_din;
        nxt_upload_req = 1'b0;
        nxt_ram_addr   = ram_addr;
        nxt_ram_rd     = ram_rd;
        nxt_abort      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (save_rise || pending) nxt_state = ST_HALT;
            end
            ST_HALT: begin
                if (paused) nxt_state = ST_ARM;
            end
            ST_ARM: begin
                nxt_upload_req = 1'b1;
                nxt_state      = ST_WAIT_UP;
            end
            ST_WAIT_UP: begin
                if (ioctl_upload && (ioctl_index == INDEX)) begin
                    nxt_state = ST_SERVE;
                end else if (tmo_expire) begin
                    nxt_state = ST_IDLE;
                    nxt_abort = 1'b1;
                end
            end
            ST_SERVE: begin
                if (!ioctl_upload) begin
                    nxt_state = ST_DONE;
                end else if (rd_hit) begin
                    // Out-of-range reads take one FETCH cycle without touching RAM.
                    nxt_state = ST_FETCH;
                    nxt_lat   = '0;
                    nxt_oor   = !in_range;
                    if (in_range) begin
                        nxt_ram_addr = ioctl_addr[ADDR_W-1:0];
                        nxt_ram_rd   = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (!ioctl_upload) begin
                    nxt_state  = ST_DONE;
                    nxt_ram_rd = 1'b0;
                end else if (oor_q) begin
                    nxt_din   = 8'h00;
                    nxt_state = ST_SERVE;
                end else if (lat_cnt == LAT_LAST) begin
                    nxt_din    = ram_data;
                    nxt_ram_rd = 1'b0;
                    nxt_state  = ST_SERVE;
                end else begin
                    nxt_lat = lat_cnt + HS_LAT_W'(1);
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state = ST_IDLE;
            end
        endcase

        // One request may queue while busy; it is consumed when HALT is entered.
        if ((state == ST_IDLE) && (nxt_state == ST_HALT)) begin
            nxt_pending = 1'b0;
        end else if (save_rise && (state != ST_IDLE)) begin
            nxt_pending = 1'b1;
        end

        nxt_pause_req = (nxt_state inside {ST_HALT, ST_ARM, ST_WAIT_UP, ST_SERVE, ST_FETCH});
        nxt_busy      = (nxt_state != ST_IDLE);
    end

endmodule

// File: tb/tb_hs_uploader.sv
// Scoreboard bench for hs_uploader: stimulus queues timed expectations, a monitor checks them.
module tb_hs_uploader;

    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned LENGTH    = 32;
    localparam int unsigned RAM_LAT   = 1;
    localparam int unsigned TIMEOUT_W = 4;

    typedef enum int {S_DIN, S_UPREQ, S_PAUSE, S_RAMRD, S_RAMADDR, S_BUSY, S_ABORT} sig_e;

    typedef struct {
        int unsigned cyc;
        sig_e        sig;
        logic [31:0] val;
    } exp_t;

    logic              clk_sys;
    logic              reset_n;
    logic              save_req;
    logic              paused;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_index;
    logic [7:0]        ram_data;
    logic [7:0]        ioctl_din;
    logic              upload_req;
    logic              pause_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic              busy;
    logic              abort;

    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    exp_t        sb[$];
    int unsigned cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_up    = 0;
    int          exp_up  = 0;
    logic [7:0]  last_din = 8'h00;

    hs_uploader #(
        .ADDR_W    (ADDR_W),
        .LENGTH    (LENGTH),
        .RAM_LAT   (RAM_LAT),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .save_req     (save_req),
        .paused       (paused),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_index  (ioctl_index),
        .ram_data     (ram_data),
        .ioctl_din    (ioctl_din),
        .upload_req   (upload_req),
        .pause_req    (pause_req),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .busy         (busy),
        .abort        (abort)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Game RAM with one cycle of read latency.
    always @(posedge clk_sys) ram_data <= mem[ram_addr];

    function automatic logic [31:0] get_sig(input sig_e s);
        case (s)
            S_DIN:     return 32'(ioctl_din);
            S_UPREQ:   return 32'(upload_req);
            S_PAUSE:   return 32'(pause_req);
            S_RAMRD:   return 32'(ram_rd);
            S_RAMADDR: return 32'(ram_addr);
            S_BUSY:    return 32'(busy);
            S_ABORT:   return 32'(abort);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic want(input sig_e s, input int unsigned d, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + d;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Monitor: compare every expectation due at this cycle, count upload pulses.
    always @(negedge clk_sys) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_tests++;
                if (get_sig(sb[i].sig) !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h",
                             sb[i].sig.name(), cyc, get_sig(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end
        end
        if (upload_req === 1'b1) n_up++;
    end

    // One ioctl byte read in SERVE; expectations cover timing, RAM strobe and hold.
    task automatic do_read(input logic [24:0] a, input logic [7:0] e);
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        if (a < 25'(LENGTH)) begin
            want(S_RAMRD,   1, 32'd1);
            want(S_RAMADDR, 1, 32'(a[ADDR_W-1:0]));
            want(S_RAMRD,   RAM_LAT + 1, 32'd1);
            want(S_DIN,     RAM_LAT + 1, 32'(last_din));
            want(S_DIN,     RAM_LAT + 2, 32'(e));
            want(S_RAMRD,   RAM_LAT + 2, 32'd0);
        end else begin
            want(S_RAMRD, 1, 32'd0);
            want(S_RAMRD, 2, 32'd0);
            want(S_DIN,   1, 32'(last_din));
            want(S_DIN,   2, 32'(e));
        end
        want(S_DIN, RAM_LAT + 3, 32'(e));
        step(1);
        ioctl_rd = 1'b0;
        step(RAM_LAT + 3);
        last_din = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i * 3 + 1);
        mem[16] = 8'hA5;

        reset_n      = 1'b0;
        save_req     = 1'b0;
        paused       = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 25'h0;
        ioctl_index  = 8'd4;

        // Reset values.
        step(2);
        want(S_DIN, 1, 0); want(S_UPREQ, 1, 0); want(S_PAUSE, 1, 0); want(S_RAMRD, 1, 0);
        want(S_RAMADDR, 1, 0); want(S_BUSY, 1, 0); want(S_ABORT, 1, 0);
        step(1);
        reset_n = 1'b1;
        step(2);

        // Save request, halt, upload_req one cycle after paused.
        save_req = 1'b1;
        want(S_PAUSE, 1, 1); want(S_BUSY, 1, 1); want(S_UPREQ, 1, 0);
        step(3);
        save_req = 1'b0;
        step(2);
        paused = 1'b1;
        want(S_UPREQ, 1, 0); want(S_UPREQ, 2, 1); want(S_UPREQ, 3, 0);
        exp_up++;
        step(2);

        // Read strobe while still waiting for the upload window is ignored.
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h010;
        want(S_RAMRD, 1, 0); want(S_RAMRD, 2, 0);
        step(1);
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b1;
        want(S_BUSY, 1, 1); want(S_PAUSE, 1, 1);
        step(2);

        // Directed reads: in range, first out of range, last in range, aliased high address.
        do_read(25'h0000010, 8'hA5);
        do_read(25'h0000020, 8'h00);
        do_read(25'h000001F, 8'h5E);
        do_read(25'h1000010, 8'h00);
        do_read(25'h0000000, 8'h01);

        // Second strobe during FETCH must not start another read.
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h01F;
        want(S_DIN, 3, 32'h5E); want(S_RAMADDR, 3, 32'h01F);
        want(S_RAMRD, 3, 0); want(S_RAMRD, 4, 0); want(S_DIN, 5, 32'h5E);
        step(1);
        ioctl_addr = 25'h000;
        step(1);
        ioctl_rd = 1'b0;
        step(4);
        last_din = 8'h5E;

        // Strobe with a foreign index is ignored.
        ioctl_index = 8'd5;
        ioctl_rd    = 1'b1;
        ioctl_addr  = 25'h010;
        want(S_RAMRD, 1, 0); want(S_DIN, 2, 32'(last_din)); want(S_DIN, 3, 32'(last_din));
        step(1);
        ioctl_rd = 1'b0;
        step(3);
        ioctl_index = 8'd4;

        // Two save edges while serving collapse into one pending request.
        save_req = 1'b1; step(1);
        save_req = 1'b0; step(1);
        save_req = 1'b1; step(1);
        save_req = 1'b0; step(2);

        // Upload window closes: DONE, IDLE, then the pending request halts again.
        ioctl_upload = 1'b0;
        want(S_PAUSE, 1, 0); want(S_BUSY, 1, 1); want(S_BUSY, 2, 0);
        want(S_PAUSE, 3, 1); want(S_BUSY, 3, 1);
        step(1);
        paused = 1'b0;
        step(3);
        paused = 1'b1;
        want(S_UPREQ, 1, 0); want(S_UPREQ, 2, 1); want(S_UPREQ, 3, 0);
        exp_up++;

        // HPS never opens the window: abort 16 cycles after upload_req.
        want(S_ABORT, 17, 0); want(S_PAUSE, 17, 1);
        want(S_ABORT, 18, 1); want(S_PAUSE, 18, 0); want(S_BUSY, 18, 0);
        want(S_ABORT, 19, 0); want(S_BUSY, 22, 0); want(S_PAUSE, 22, 0);
        step(18);
        paused = 1'b0;
        step(5);

        // New transfer, then reset while a RAM fetch is in flight.
        save_req = 1'b1;
        step(1);
        save_req = 1'b0;
        step(2);
        paused = 1'b1;
        want(S_UPREQ, 2, 1);
        exp_up++;
        step(2);
        ioctl_upload = 1'b1;
        step(2);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h010;
        want(S_RAMRD, 1, 1);
        step(1);
        ioctl_rd     = 1'b0;
        reset_n      = 1'b0;
        want(S_DIN, 1, 0); want(S_UPREQ, 1, 0); want(S_PAUSE, 1, 0); want(S_RAMRD, 1, 0);
        want(S_RAMADDR, 1, 0); want(S_BUSY, 1, 0); want(S_ABORT, 1, 0);
        want(S_UPREQ, 2, 0);
        step(1);
        paused       = 1'b0;
        ioctl_upload = 1'b0;
        step(1);
        reset_n = 1'b1;
        want(S_BUSY, 2, 0); want(S_PAUSE, 2, 0); want(S_UPREQ, 3, 0); want(S_BUSY, 4, 0);
        step(6);

        // Anything still queued was never checked.
        foreach (sb[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL unchecked %s due=%0d want=%0h", sb[i].sig.name(), sb[i].cyc, sb[i].val);
        end

        n_tests++;
        if (n_up != exp_up) begin
            n_fail++;
            $display("FAIL upload_req_pulses got=%0d want=%0d", n_up, exp_up);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hs_uploader.md
HS_UPLOADER -- requirements
Module: hs_uploader

Interface
REQ-001 SHALL have parameter INDEX, default 8'd4: ioctl_index value this block serves.
REQ-002 SHALL have parameter ADDR_W, default 11: game-RAM address width.
REQ-003 SHALL have parameter LENGTH, default 2048: bytes per save image, at most 2^ADDR_W.
REQ-004 SHALL have parameter RAM_LAT, default 1: game-RAM read latency in cycles, range 1..3.
REQ-005 SHALL have parameter TIMEOUT_W, default 24: width of the upload-start timeout counter.
REQ-006 clk_sys  in  1  sole clock.
REQ-007 reset_n  in  1  synchronous, active-low reset.
REQ-008 save_req  in  1  level; its rising edge requests a save.
REQ-009 paused  in  1  core CPU is halted.
REQ-010 ioctl_upload  in  1  HPS upload window is active.
REQ-011 ioctl_rd  in  1  one-cycle byte-read strobe.
REQ-012 ioctl_addr  in  25  byte address for ioctl_rd.
REQ-013 ioctl_index  in  8  selected transfer index.
REQ-014 ram_data  in  8  game-RAM read data.
REQ-015 ioctl_din  out  8  byte returned to HPS.
REQ-016 upload_req  out  1  one-cycle request to HPS to start an upload.
REQ-017 pause_req  out  1  core halt request.
REQ-018 ram_addr  out  ADDR_W  game-RAM read address.
REQ-019 ram_rd  out  1  game-RAM read intent.
REQ-020 busy  out  1  high whenever the state is not IDLE.
REQ-021 abort  out  1  one-cycle pulse on timeout.

Function
REQ-022 FSM states SHALL be IDLE, HALT, ARM, WAIT_UP, SERVE, FETCH, DONE.
REQ-023 IDLE -> HALT SHALL occur on a save_req rising edge or a pending flag; HALT asserts pause_req.
REQ-024 HALT -> ARM SHALL occur when paused=1; ARM drives upload_req=1 for exactly one cycle, then goes to WAIT_UP.
REQ-025 WAIT_UP -> SERVE SHALL occur when ioctl_upload=1 and ioctl_index==INDEX.
REQ-026 WAIT_UP SHALL count cycles; at 2^TIMEOUT_W-1 it pulses abort, drops pause_req and returns to IDLE.
REQ-027 In SERVE, ioctl_rd=1 SHALL latch ioctl_addr[ADDR_W-1:0] into ram_addr, assert ram_rd and enter FETCH.
REQ-028 FETCH SHALL wait RAM_LAT cycles, load ioctl_din from ram_data, drop ram_rd and return to SERVE; ioctl_din is valid RAM_LAT+1 cycles after ioctl_rd.
REQ-029 Addresses >= LENGTH SHALL return ioctl_din=8'h00 with no RAM read, one cycle after ioctl_rd.
REQ-030 An ioctl_rd arriving while in FETCH SHALL be ignored.
REQ-031 ioctl_upload falling in SERVE or FETCH SHALL go to DONE; DONE drops pause_req and goes to IDLE next cycle.
REQ-032 A save_req rising edge while busy=1 SHALL set a single pending flag, cleared on HALT entry; further edges are not counted.
REQ-033 ioctl_rd while ioctl_index!=INDEX, or outside SERVE, SHALL be ignored.
REQ-034 ioctl_din SHALL hold its last value between reads.

Reset
REQ-035 reset_n=0 at a clk_sys edge SHALL force IDLE and clear the pending flag, timeout counter and save_req edge register.
REQ-036 The same reset SHALL drive ioctl_din=0, upload_req=0, pause_req=0, ram_rd=0, ram_addr=0, busy=0, abort=0.
REQ-037 Reset mid-transfer SHALL release pause_req on the next cycle with no upload_req pulse.

Structure
REQ-038 The state enum and HS_INDEX_DEFAULT SHALL live in shared package hs_pkg.
REQ-039 The timeout counter SHALL be sub-module hs_timeout (clear, enable, expire).

Verification
REQ-040 save_req rise, paused=1 after 5 cycles -> upload_req pulses once, exactly 1 cycle after paused.
REQ-041 RAM[0x010]=8'hA5, ioctl_rd with addr 0x010 -> ioctl_din=8'hA5 two cycles later (RAM_LAT=1).
REQ-042 LENGTH=16, read addr 0x020 -> ioctl_din=8'h00 after 1 cycle, ram_rd never asserted.
REQ-043 TIMEOUT_W=4, ioctl_upload never rises -> abort pulses at count 15, pause_req=0, state IDLE.
REQ-044 save_req rises twice during SERVE -> after DONE exactly one further HALT/ARM sequence.
REQ-045 reset_n=0 during FETCH -> next cycle all outputs 0, busy=0.
